// File: rtl/axil_csr_slave_pkg.sv
// Shared AXI4-Lite constants and helpers for the CSR responder.
package axil_csr_slave_pkg;

    localparam int AXIL_DATA_BITS = 64;
    localparam int AXIL_ADDR_BITS = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_for(input logic hit);
        return hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axil_csr_wr_join.sv
// Joins independent AW and W beats into a single commit strobe with latched index/data/strobe.
module axil_csr_wr_join
    import axil_csr_slave_pkg::*;
#(
    parameter int DATA_BITS = AXIL_DATA_BITS,
    parameter int IDX_BITS  = 4
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [IDX_BITS-1:0]    aw_idx,
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [DATA_BITS-1:0]   wdata,
    input  logic [DATA_BITS/8-1:0] wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic                   b_busy_next,
    output logic                   commit,
    output logic [IDX_BITS-1:0]    c_idx,
    output logic [DATA_BITS-1:0]   c_data,
    output logic [DATA_BITS/8-1:0] c_strb
);

    logic aw_full, w_full, aw_full_next, w_full_next;
    logic aw_hs, w_hs;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign commit = aw_full && w_full;

    always_comb begin
        aw_full_next = aw_full;
        w_full_next  = w_full;
        if (commit) begin
            aw_full_next = 1'b0;
            w_full_next  = 1'b0;
        end else begin
            if (aw_hs) aw_full_next = 1'b1;
            if (w_hs)  w_full_next  = 1'b1;
        end
    end

    // Readies are registered from next-state so they drop the cycle a latch fills
    // and stay low while a B response is pending.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            c_idx   <= '0;
            c_data  <= '0;
            c_strb  <= '0;
        end else begin
            aw_full <= aw_full_next;
            w_full  <= w_full_next;
            awready <= !aw_full_next && !b_busy_next;
            wready  <= !w_full_next && !b_busy_next;
            if (aw_hs) c_idx <= aw_idx;
            if (w_hs) begin
                c_data <= wdata;
                c_strb <= wstrb;
            end
        end
    end

endmodule

// File: rtl/axil_csr_slave.sv
// AXI4-Lite CSR responder: RW control registers followed by RO status registers.
module axil_csr_slave
    import axil_csr_slave_pkg::*;
#(
    parameter int N_RW_REGS = 8,
    parameter int N_RO_REGS = 8,
    parameter int DATA_BITS = AXIL_DATA_BITS,
    parameter int ADDR_BITS = AXIL_ADDR_BITS,
    parameter int ADDR_LSB  = $clog2(DATA_BITS/8)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_BITS-1:0]           s_ctrl_awaddr,
    input  logic [2:0]                     s_ctrl_awprot,
    input  logic [3:0]                     s_ctrl_awqos,
    input  logic [3:0]                     s_ctrl_awregion,
    input  logic                           s_ctrl_awvalid,
    output logic                           s_ctrl_awready,
    input  logic [DATA_BITS-1:0]           s_ctrl_wdata,
    input  logic [DATA_BITS/8-1:0]         s_ctrl_wstrb,
    input  logic                           s_ctrl_wvalid,
    output logic                           s_ctrl_wready,
    output logic [1:0]                     s_ctrl_bresp,
    output logic                           s_ctrl_bvalid,
    input  logic                           s_ctrl_bready,
    input  logic [ADDR_BITS-1:0]           s_ctrl_araddr,
    input  logic [2:0]                     s_ctrl_arprot,
    input  logic [3:0]                     s_ctrl_arqos,
    input  logic [3:0]                     s_ctrl_arregion,
    input  logic                           s_ctrl_arvalid,
    output logic                           s_ctrl_arready,
    output logic [DATA_BITS-1:0]           s_ctrl_rdata,
    output logic [1:0]                     s_ctrl_rresp,
    output logic                           s_ctrl_rvalid,
    input  logic                           s_ctrl_rready,
    output logic [N_RW_REGS*DATA_BITS-1:0] ctrl_regs,
    output logic [N_RW_REGS-1:0]           ctrl_wr_pulse,
    input  logic [N_RO_REGS*DATA_BITS-1:0] stat_regs
);

    localparam int N_TOT     = N_RW_REGS + N_RO_REGS;
    localparam int IDX_BITS  = $clog2(N_TOT);
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam logic [IDX_BITS:0] RW_END  = (IDX_BITS+1)'(N_RW_REGS);
    localparam logic [IDX_BITS:0] TOT_END = (IDX_BITS+1)'(N_TOT);

    logic [N_RW_REGS-1:0][DATA_BITS-1:0] regs;
    logic [N_RO_REGS-1:0][DATA_BITS-1:0] stat;
    logic [IDX_BITS-1:0]  aw_idx, ar_idx, c_idx;
    logic [DATA_BITS-1:0] c_data, rd_data;
    logic [STRB_BITS-1:0] c_strb;
    logic [1:0]           rd_resp;
    logic                 commit, wr_hit, bvalid_next, ar_hs;
    logic                 unused_ok;

    assign stat      = stat_regs;
    assign ctrl_regs = regs;
    assign aw_idx    = s_ctrl_awaddr[ADDR_LSB +: IDX_BITS];
    assign ar_idx    = s_ctrl_araddr[ADDR_LSB +: IDX_BITS];
    assign unused_ok = ^{s_ctrl_awaddr, s_ctrl_araddr, s_ctrl_awprot, s_ctrl_arprot,
                         s_ctrl_awqos, s_ctrl_arqos, s_ctrl_awregion, s_ctrl_arregion};

    axil_csr_wr_join #(
        .DATA_BITS (DATA_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_wr_join (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .aw_idx      (aw_idx),
        .awvalid     (s_ctrl_awvalid),
        .awready     (s_ctrl_awready),
        .wdata       (s_ctrl_wdata),
        .wstrb       (s_ctrl_wstrb),
        .wvalid      (s_ctrl_wvalid),
        .wready      (s_ctrl_wready),
        .b_busy_next (bvalid_next),
        .commit      (commit),
        .c_idx       (c_idx),
        .c_data      (c_data),
        .c_strb      (c_strb)
    );

    assign wr_hit      = commit && ({1'b0, c_idx} < RW_END);
    assign bvalid_next = commit || (s_ctrl_bvalid && !s_ctrl_bready);

    always_comb begin
        ctrl_wr_pulse = '0;
        for (int i = 0; i < N_RW_REGS; i++)
            ctrl_wr_pulse[i] = wr_hit && (c_idx == IDX_BITS'(i));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            regs <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < N_RW_REGS; i++)
                for (int b = 0; b < STRB_BITS; b++)
                    if (c_idx == IDX_BITS'(i) && c_strb[b])
                        regs[i][b*8 +: 8] <= c_data[b*8 +: 8];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_ctrl_bvalid <= 1'b0;
            s_ctrl_bresp  <= '0;
        end else begin
            s_ctrl_bvalid <= bvalid_next;
            if (commit) s_ctrl_bresp <= resp_for(wr_hit);
        end
    end

    // Read mux samples regs before any same-cycle commit lands, so reads see the old value.
    always_comb begin
        rd_data = '0;
        rd_resp = AXI_RESP_SLVERR;
        if ({1'b0, ar_idx} < RW_END) begin
            rd_resp = AXI_RESP_OKAY;
            for (int i = 0; i < N_RW_REGS; i++)
                if (ar_idx == IDX_BITS'(i)) rd_data = regs[i];
        end else if ({1'b0, ar_idx} < TOT_END) begin
            rd_resp = AXI_RESP_OKAY;
            for (int j = 0; j < N_RO_REGS; j++)
                if (ar_idx == IDX_BITS'(N_RW_REGS + j)) rd_data = stat[j];
        end
    end

    assign ar_hs = s_ctrl_arvalid && s_ctrl_arready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s_ctrl_arready <= 1'b0;
            s_ctrl_rvalid  <= 1'b0;
            s_ctrl_rdata   <= '0;
            s_ctrl_rresp   <= '0;
        end else begin
            s_ctrl_arready <= !(ar_hs || (s_ctrl_rvalid && !s_ctrl_rready));
            if (ar_hs) begin
                s_ctrl_rvalid <= 1'b1;
                s_ctrl_rdata  <= rd_data;
                s_ctrl_rresp  <= rd_resp;
            end else if (s_ctrl_rready) begin
                s_ctrl_rvalid <= 1'b0;
            end
        end
    end

endmodule
